graph_loader: RTL and testbench
===============================

GRAPH_LOADER -- requirements
Module: graph_loader

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): ADDR_W, 13, graph-memory address width; ROW_W, 128, graph-memory word width; MAX_PAIRS, 7, (V,W) pairs per adjacency row.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
 clock  in  1  rising-edge clock;
 reset  in  1  synchronous, active-low;
 start  in  1  one-cycle pulse, begin a load;
 num_nodes  in  8  node count, sampled on start;
 edge_valid  in  1  edge beat valid;
 edge_ready  out  1  edge beat accepted when valid&ready;
 edge_src  in  8  source node U, 1..num_nodes;
 edge_dst  in  8  destination node V;
 edge_wt  in  8  signed edge weight;
 edge_last  in  1  final edge of the load;
 GMWAR  out  13  graph-memory write address;
 GMWDR  out  128  graph-memory write data;
 GMWE  out  1  graph-memory write enable;
 done  out  1  load complete, level;
 err  out  1  load aborted, level.

Function
REQ-003 Row format SHALL be [127:120]=U, [119:112]=link count 1..7, [111:0]=pairs V1,W1..V7,W7 (V1 at [111:104], W1 at [103:96]), with unused pairs zero.
REQ-004 Header at address 0 SHALL be [127:77]=0, [76:64]=row count, [63:8]=0, [7:0]=num_nodes.
REQ-005 Adjacency rows SHALL be written to consecutive addresses starting at 1; a source with more than 7 edges SHALL occupy consecutive rows with the same U.
REQ-006 FSM states SHALL be IDLE, COLLECT, FLUSH, HEADER, DONE, ERR.
REQ-007 IDLE->COLLECT on start: latch num_nodes, clear pair count, set row address to 1, clear done/err.
REQ-008 edge_ready SHALL equal (state==COLLECT) and SHALL be registered, not derived from edge inputs.
REQ-009 On an accepted beat with count==0 or edge_src==current U, the edge SHALL be appended and the count incremented; go to FLUSH if the count reaches 7 or edge_last=1, else stay in COLLECT.
REQ-010 On an accepted beat with count>0 and edge_src>current U, the edge SHALL be held in a pending register and the state SHALL go to FLUSH; after that flush the pending edge SHALL become pair 1 of a new row (count=1), then go to FLUSH if its edge_last was 1, else to COLLECT.
REQ-011 FLUSH SHALL last exactly one cycle: GMWE=1, GMWAR=row address, GMWDR=the packed row. It SHALL then increment the row address and clear the pair buffer.
REQ-012 After the flush of the last edge, HEADER SHALL write address 0 for one cycle, then go to DONE.
REQ-013 DONE and ERR SHALL hold done or err high respectively until the next start, which restarts the load from REQ-007.
REQ-014 Any of the following on an accepted beat SHALL go to ERR with no further writes: edge_src<current U; edge_src==0; edge_src>num_nodes; edge_dst==0; edge_dst>num_nodes. A row address that would exceed 8191 SHALL also go to ERR.
REQ-015 start while not in IDLE/DONE/ERR SHALL be ignored.
REQ-016 GMWE SHALL be high only in FLUSH and HEADER; edge_wt SHALL be stored unmodified (two's complement).
REQ-017 Row count SHALL equal the number of FLUSH cycles in the load.

Reset
REQ-018 With reset=0 at a clock edge, the block SHALL enter IDLE and drive edge_ready=0, GMWE=0, GMWAR=0, GMWDR=0, done=0, err=0, with count and pending cleared, including mid-load; a partially written graph is not erased.

Structure
REQ-019 A shared package SHALL hold the state enum, the row field bit positions, MAX_PAIRS and HEADER_ADDR=0, for use by this block and the graph-memory consumer.
REQ-020 One sub-module, gl_row_packer (pair buffer, count, pack/clear), SHALL be instantiated; everything else SHALL be flat.

Verification
REQ-021 num_nodes=3, edges (1,2,5),(1,3,-2),(2,3,4,last) -> row@1 U=1,cnt=2,V1=2,W1=05,V2=3,W2=FE; row@2 U=2,cnt=1; header@0 rows=2,nodes=3; then done.
REQ-022 Nine edges from U=1 -> row@1 cnt=7, row@2 U=1 cnt=2, header rows=2.
REQ-023 Edges with src 2 then src 1 -> err=1; no write after the row holding src 2 edges is still pending; GMWE stays 0.
REQ-024 Reset low during COLLECT after 3 edges -> next cycle edge_ready=0 and GMWE=0; a subsequent start performs a clean load.
REQ-025 Random edge_valid gaps with sorted sources -> the memory image matches the reference model and GMWE pulses = rows+1.

Source files
------------

// File: rtl/graph_loader_pkg.sv
// Shared definitions for the graph loader and the graph-memory consumer:
// FSM state encoding, adjacency-row / header field positions, pair limits.
package graph_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        FLUSH,
        HEADER,
        DONE,
        ERR
    } gl_state_e;

    // Adjacency row: [127:120]=U, [119:112]=link count, [111:0]=V1,W1..V7,W7
    localparam int unsigned ROW_BITS     = 128;
    localparam int unsigned ROW_U_LO     = 120;
    localparam int unsigned ROW_CNT_LO   = 112;
    localparam int unsigned ROW_PAIRS_HI = 111;
    localparam int unsigned PAIR_W       = 16;
    localparam int unsigned MAX_PAIRS    = 7;

    // Header row at address 0: [76:64]=row count, [7:0]=num_nodes
    localparam int unsigned HEADER_ADDR  = 0;
    localparam int unsigned HDR_ROWS_LO  = 64;
    localparam int unsigned HDR_ROWS_W   = 13;
    localparam int unsigned HDR_NODES_LO = 0;

    function automatic logic [ROW_BITS-1:0] pack_header(
        input logic [HDR_ROWS_W-1:0] rows,
        input logic [7:0]            nodes
    );
        logic [ROW_BITS-1:0] h;
        h = '0;
        h[HDR_ROWS_LO +: HDR_ROWS_W] = rows;
        h[HDR_NODES_LO +: 8]         = nodes;
        return h;
    endfunction

endpackage

// File: rtl/graph_loader_row_packer.sv
// Pair buffer for one adjacency row: appends (V,W) pairs, tracks the pair
// count and presents the packed row.  Clear and append in the same cycle
// leaves exactly one pair, which seeds a new row from a held edge.
module gl_row_packer #(
    parameter int unsigned ROW_W     = 128,
    parameter int unsigned MAX_PAIRS = 7,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             app_i,
    input  logic [7:0]       u_i,
    input  logic [7:0]       v_i,
    input  logic [7:0]       w_i,
    output logic [CNT_W-1:0] count_o,
    output logic [ROW_W-1:0] row_o
);
    import graph_loader_pkg::*;

    logic [PAIR_W-1:0] pairs_q [MAX_PAIRS];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  slot_d;

    // Slot that an append writes: restarts at 0 when the buffer is being cleared
    always_comb begin
        slot_d = clr_i ? '0 : count_q;
    end

    // Pair storage and count update
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            for (int unsigned i = 0; i < MAX_PAIRS; i++) pairs_q[i] <= '0;
        end else begin
            if (clr_i) begin
                count_q <= '0;
                for (int unsigned i = 0; i < MAX_PAIRS; i++) pairs_q[i] <= '0;
            end
            if (app_i) begin
                pairs_q[slot_d] <= {v_i, w_i};
                count_q         <= slot_d + CNT_W'(1);
            end
        end
    end

    // Packed row image
    always_comb begin
        row_o = '0;
        row_o[ROW_U_LO +: 8]   = u_i;
        row_o[ROW_CNT_LO +: 8] = 8'(count_q);
        for (int unsigned i = 0; i < MAX_PAIRS; i++)
            row_o[ROW_PAIRS_HI - PAIR_W*i -: PAIR_W] = pairs_q[i];
    end

    assign count_o = count_q;

endmodule

// File: rtl/graph_loader.sv
// Graph loader: accepts a stream of edges sorted by source node, packs them
// into adjacency rows written from address 1, then writes a header at 0.
module graph_loader #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned ROW_W     = 128,
    parameter int unsigned MAX_PAIRS = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        num_nodes,
    input  logic              edge_valid,
    output logic              edge_ready,
    input  logic [7:0]        edge_src,
    input  logic [7:0]        edge_dst,
    input  logic [7:0]        edge_wt,
    input  logic              edge_last,
    output logic [ADDR_W-1:0] GMWAR,
    output logic [ROW_W-1:0]  GMWDR,
    output logic              GMWE,
    output logic              done,
    output logic              err
);
    import graph_loader_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_PAIRS + 1);

    gl_state_e         state_q;
    logic [7:0]        nodes_q, cur_u_q;
    logic [ADDR_W-1:0] addr_q, rows_q, war_q;
    logic [7:0]        pend_src_q, pend_dst_q, pend_wt_q;
    logic              pend_v_q, pend_last_q, final_q;
    logic              ready_q, we_q, done_q, err_q;

    logic              accept_d, bad_d, same_row_d, full_d, start_d;
    logic              pk_clr_d, pk_app_d;
    logic [7:0]        pk_v_d, pk_w_d;
    logic [CNT_W-1:0]  pk_count;
    logic [ROW_W-1:0]  pk_row;

    gl_row_packer #(
        .ROW_W     (ROW_W),
        .MAX_PAIRS (MAX_PAIRS),
        .CNT_W     (CNT_W)
    ) u_packer (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (pk_clr_d),
        .app_i   (pk_app_d),
        .u_i     (cur_u_q),
        .v_i     (pk_v_d),
        .w_i     (pk_w_d),
        .count_o (pk_count),
        .row_o   (pk_row)
    );

    // Beat classification and packer control
    always_comb begin
        accept_d   = edge_valid & ready_q;
        bad_d      = (edge_src == 8'd0) | (edge_src > nodes_q) |
                     (edge_dst == 8'd0) | (edge_dst > nodes_q) |
                     (edge_src < cur_u_q);
        same_row_d = (pk_count == '0) | (edge_src == cur_u_q);
        full_d     = (pk_count == CNT_W'(MAX_PAIRS - 1));
        start_d    = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
        // The flush cycle clears the buffer and, if an edge is held, seeds it as pair 1
        pk_clr_d   = start_d | (state_q == FLUSH);
        pk_app_d   = (accept_d & ~bad_d & same_row_d) | ((state_q == FLUSH) & pend_v_q);
        pk_v_d     = (state_q == FLUSH) ? pend_dst_q : edge_dst;
        pk_w_d     = (state_q == FLUSH) ? pend_wt_q  : edge_wt;
    end

    // Load sequencing FSM with registered handshake/write-enable/status outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            nodes_q     <= '0;
            cur_u_q     <= '0;
            addr_q      <= '0;
            rows_q      <= '0;
            war_q       <= '0;
            pend_src_q  <= '0;
            pend_dst_q  <= '0;
            pend_wt_q   <= '0;
            pend_v_q    <= 1'b0;
            pend_last_q <= 1'b0;
            final_q     <= 1'b0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_d) begin
                        state_q  <= COLLECT;
                        nodes_q  <= num_nodes;
                        cur_u_q  <= '0;
                        addr_q   <= ADDR_W'(1);
                        rows_q   <= '0;
                        pend_v_q <= 1'b0;
                        final_q  <= 1'b0;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept_d) begin
                        if (bad_d) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (same_row_d) begin
                            cur_u_q <= edge_src;
                            if (full_d | edge_last) begin
                                state_q <= FLUSH;
                                ready_q <= 1'b0;
                                we_q    <= 1'b1;
                                war_q   <= addr_q;
                                final_q <= edge_last;
                            end
                        end else begin
                            pend_src_q  <= edge_src;
                            pend_dst_q  <= edge_dst;
                            pend_wt_q   <= edge_wt;
                            pend_last_q <= edge_last;
                            pend_v_q    <= 1'b1;
                            state_q     <= FLUSH;
                            ready_q     <= 1'b0;
                            we_q        <= 1'b1;
                            war_q       <= addr_q;
                            final_q     <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    rows_q <= rows_q + ADDR_W'(1);
                    if (final_q) begin
                        state_q <= HEADER;
                        war_q   <= ADDR_W'(HEADER_ADDR);
                    end else if (addr_q == '1) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        we_q    <= 1'b0;
                        war_q   <= '0;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (pend_v_q && pend_last_q) begin
                            // held edge was the final one: its row flushes next cycle
                            pend_v_q <= 1'b0;
                            cur_u_q  <= pend_src_q;
                            final_q  <= 1'b1;
                            war_q    <= addr_q + ADDR_W'(1);
                        end else begin
                            if (pend_v_q) cur_u_q <= pend_src_q;
                            pend_v_q <= 1'b0;
                            state_q  <= COLLECT;
                            ready_q  <= 1'b1;
                            we_q     <= 1'b0;
                            war_q    <= '0;
                        end
                    end
                end
                HEADER: begin
                    state_q <= DONE;
                    we_q    <= 1'b0;
                    war_q   <= '0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write data: packed row in FLUSH, header in HEADER, zero otherwise
    always_comb begin
        GMWDR = '0;
        if (state_q == FLUSH)
            GMWDR = pk_row;
        else if (state_q == HEADER)
            GMWDR = ROW_W'(pack_header(HDR_ROWS_W'(rows_q), nodes_q));
    end

    assign edge_ready = ready_q;
    assign GMWE       = we_q;
    assign GMWAR      = war_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_graph_loader.sv
// Directed testbench for graph_loader: captures every memory write and
// compares rows, header, write counts and status against literal values.
module tb_graph_loader;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   num_nodes = '0;
    logic         edge_valid = 1'b0;
    logic         edge_ready;
    logic [7:0]   edge_src = '0, edge_dst = '0, edge_wt = '0;
    logic         edge_last = 1'b0;
    logic [12:0]  GMWAR;
    logic [127:0] GMWDR;
    logic         GMWE;
    logic         done, err;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    int unsigned  we_cnt = 0;
    logic [127:0] mem [int];

    graph_loader #(
        .ADDR_W    (13),
        .ROW_W     (128),
        .MAX_PAIRS (7)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_nodes  (num_nodes),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .edge_src   (edge_src),
        .edge_dst   (edge_dst),
        .edge_wt    (edge_wt),
        .edge_last  (edge_last),
        .GMWAR      (GMWAR),
        .GMWDR      (GMWDR),
        .GMWE       (GMWE),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Memory image capture
    always @(negedge clock) begin
        if (GMWE) begin
            mem[int'(GMWAR)] = GMWDR;
            we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rd(input int a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    task automatic begin_load(input logic [7:0] n);
        mem.delete();
        we_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        num_nodes = n;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_edge(input logic [7:0] s, input logic [7:0] d, input logic [7:0] w,
                             input logic l, input int unsigned gap);
        bit ok;
        repeat (gap) @(negedge clock);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (edge_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        edge_valid = 1'b1;
        edge_src = s;
        edge_dst = d;
        edge_wt = w;
        edge_last = l;
        @(posedge clock);
        @(negedge clock);
        edge_valid = 1'b0;
        edge_last = 1'b0;
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done || err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) chk("end_timeout", 0, 1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_ready", 128'(edge_ready), 0);
        chk("rst_we",    128'(GMWE), 0);
        chk("rst_war",   128'(GMWAR), 0);
        chk("rst_wdr",   GMWDR, 0);
        chk("rst_done",  128'(done), 0);
        chk("rst_err",   128'(err), 0);
        reset = 1'b1;

        // Basic three-edge load with negative weight and source change on the last edge
        begin_load(8'd3);
        chk("t1_ready", 128'(edge_ready), 1);
        send_edge(8'd1, 8'd2, 8'h05, 1'b0, 0);
        send_edge(8'd1, 8'd3, 8'hFE, 1'b0, 0);
        send_edge(8'd2, 8'd3, 8'h04, 1'b1, 0);
        wait_end();
        chk("t1_row1", rd(1), 128'h0102_0205_03FE_0000_0000_0000_0000_0000);
        chk("t1_row2", rd(2), 128'h0201_0304_0000_0000_0000_0000_0000_0000);
        chk("t1_hdr",  rd(0), 128'h0000_0000_0000_0002_0000_0000_0000_0003);
        chk("t1_wes",  128'(we_cnt), 3);
        chk("t1_done", 128'(done), 1);
        chk("t1_err",  128'(err), 0);
        repeat (3) @(negedge clock);
        chk("t1_hold", 128'(done), 1);

        // Nine edges from one source spill into a second row
        begin_load(8'd9);
        chk("t2_doneclr", 128'(done), 0);
        for (int i = 1; i <= 9; i++)
            send_edge(8'd1, 8'(i), 8'(8'h10 + i), (i == 9), 0);
        wait_end();
        chk("t2_row1", rd(1), 128'h0107_0111_0212_0313_0414_0515_0616_0717);
        chk("t2_row2", rd(2), 128'h0102_0818_0919_0000_0000_0000_0000_0000);
        chk("t2_hdr",  rd(0), 128'h0000_0000_0000_0002_0000_0000_0000_0009);
        chk("t2_wes",  128'(we_cnt), 3);

        // Descending source aborts before the pending row is written
        begin_load(8'd3);
        send_edge(8'd2, 8'd1, 8'h01, 1'b0, 0);
        send_edge(8'd1, 8'd1, 8'h01, 1'b0, 0);
        wait_end();
        repeat (3) @(negedge clock);
        chk("t3_err",  128'(err), 1);
        chk("t3_done", 128'(done), 0);
        chk("t3_wes",  128'(we_cnt), 0);

        // Destination beyond num_nodes aborts
        begin_load(8'd3);
        send_edge(8'd1, 8'd4, 8'h01, 1'b1, 0);
        wait_end();
        chk("t4_err", 128'(err), 1);
        chk("t4_wes", 128'(we_cnt), 0);

        // Destination zero aborts
        begin_load(8'd3);
        send_edge(8'd1, 8'd0, 8'h01, 1'b1, 0);
        wait_end();
        chk("t5_err", 128'(err), 1);

        // Reset mid-collect, then a clean load
        begin_load(8'd5);
        send_edge(8'd1, 8'd1, 8'h01, 1'b0, 0);
        send_edge(8'd1, 8'd2, 8'h02, 1'b0, 0);
        send_edge(8'd1, 8'd3, 8'h03, 1'b0, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("t6_ready", 128'(edge_ready), 0);
        chk("t6_we",    128'(GMWE), 0);
        chk("t6_wdr",   GMWDR, 0);
        reset = 1'b1;
        begin_load(8'd2);
        send_edge(8'd1, 8'd2, 8'hFF, 1'b0, 0);
        send_edge(8'd2, 8'd1, 8'h07, 1'b1, 0);
        wait_end();
        chk("t6_row1", rd(1), 128'h0101_02FF_0000_0000_0000_0000_0000_0000);
        chk("t6_row2", rd(2), 128'h0201_0107_0000_0000_0000_0000_0000_0000);
        chk("t6_hdr",  rd(0), 128'h0000_0000_0000_0002_0000_0000_0000_0002);
        chk("t6_done", 128'(done), 1);

        // Random valid gaps with sorted sources
        begin_load(8'd4);
        send_edge(8'd1, 8'd2, 8'h01, 1'b0, $urandom_range(0, 3));
        send_edge(8'd1, 8'd3, 8'h02, 1'b0, $urandom_range(0, 3));
        send_edge(8'd3, 8'd4, 8'h03, 1'b0, $urandom_range(0, 3));
        send_edge(8'd4, 8'd1, 8'h04, 1'b0, $urandom_range(0, 3));
        send_edge(8'd4, 8'd2, 8'h05, 1'b0, $urandom_range(0, 3));
        send_edge(8'd4, 8'd3, 8'h06, 1'b1, $urandom_range(0, 3));
        wait_end();
        chk("t7_row1", rd(1), 128'h0102_0201_0302_0000_0000_0000_0000_0000);
        chk("t7_row2", rd(2), 128'h0301_0403_0000_0000_0000_0000_0000_0000);
        chk("t7_row3", rd(3), 128'h0403_0104_0205_0306_0000_0000_0000_0000);
        chk("t7_hdr",  rd(0), 128'h0000_0000_0000_0003_0000_0000_0000_0004);
        chk("t7_wes",  128'(we_cnt), 4);
        chk("t7_done", 128'(done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
